mips_run_monitor: RTL

Synthesizable run controller for the 32-bit MIPS core: starts a program run on command, counts clock cycles and retired fetch addresses, and ends the run on halt request, PC self-loop (e.g. `j .`), optional end address, or cycle-budget timeout. It sits beside the core, observing its PC, and replaces fixed-delay run control with an explicit done/timeout status that benches and on-board logic can poll.

---
 rtl/mips_run_monitor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mips_run_monitor.sv
// mips_run_monitor: run controller for the MIPS core. It starts a run on
// command, counts RUN cycles and PC changes, and ends the run on a halt
// request, a PC self-loop, an optional end address or a cycle budget.
module mips_run_monitor #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        CNT_W       = 32,
  parameter int unsigned        MAX_CYCLES  = 2000,
  parameter int unsigned        STALL_LIMIT = 4,
  parameter bit                 END_EN      = 1'b0,
  parameter logic [ADDR_W-1:0]  END_ADDR    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt_req,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired,
  output logic [ADDR_W-1:0] last_pc
);

  localparam int unsigned        STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(MAX_CYCLES);
  // The run exits when the stall count reaches STALL_LIMIT; compare the
  // pre-increment value so no extra adder bit is needed.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t              state_q,   state_d;
  logic                running_q, running_d;
  logic                done_q,    done_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cycle_q,   cycle_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [ADDR_W-1:0]   last_pc_q, last_pc_d;
  logic [STALL_W-1:0]  stall_q,   stall_d;
  logic                pc_same;

  assign pc_same = (pc == last_pc_q);

  // Next-state logic: start handling outside RUN, counting and exit checks inside it.
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    last_pc_d = last_pc_q;
    stall_d   = stall_q;

    case (state_q)
      S_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (pc_same) begin
          stall_d = stall_q + STALL_W'(1);
        end else begin
          last_pc_d = pc;
          retired_d = retired_q + CNT_W'(1);
          stall_d   = '0;
        end

        // Normal end takes priority over the cycle budget.
        if (halt_req || (pc_same && (stall_q == STALL_LAST)) ||
            (END_EN && (pc == END_ADDR))) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else if (cycle_d == MAX_C) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
          running_d = 1'b0;
        end
      end

      default: begin
        if (start) begin
          state_d   = S_RUN;
          running_d = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cycle_d   = '0;
          retired_d = '0;
          stall_d   = '0;
          last_pc_d = pc;
        end
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycle_q   <= '0;
      retired_q <= '0;
      last_pc_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      last_pc_q <= last_pc_d;
      stall_q   <= stall_d;
    end
  end

  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign retired     = retired_q;
  assign last_pc     = last_pc_q;

endmodule
